// File: rtl/mem_ls_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory with a registered read port.
// Handles byte/half/word loads with extension and builds sub-word stores by read-modify-write.
module mem_ls_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [9:0]  mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_READ, S_EXT, S_MERGE, S_WRITE, S_DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [9:0]  r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_shifted;
  logic [31:0] w_load_val;
  logic [31:0] w_pos_wdata;
  logic [31:0] w_merged;
  logic        w_unused;

  // Upper address bits fall outside the 4 KiB data memory.
  assign w_unused = ^addr[31:12];

  // size 11 behaves exactly like a word access.
  assign w_misaligned = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    w_be = 4'b1111;
    if (!size[1]) begin
      if (size[0]) w_be = addr[1] ? 4'b1100 : 4'b0011;
      else         w_be = 4'b0001 << addr[1:0];
    end
  end

  // Halfwords are aligned, so the byte-offset shift also brings a half down to lane 0.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_val = mem_rdata;
    if (!r_size[1]) begin
      if (r_size[0])
        w_load_val = r_sext ? {{16{w_shifted[15]}}, w_shifted[15:0]} : {16'h0000, w_shifted[15:0]};
      else
        w_load_val = r_sext ? {{24{w_shifted[7]}}, w_shifted[7:0]} : {24'h000000, w_shifted[7:0]};
    end
  end

  always_comb begin
    w_pos_wdata = r_wdata;
    if (!r_size[1]) begin
      if (r_size[0]) w_pos_wdata = {16'h0000, r_wdata[15:0]} << {r_off[1], 4'b0000};
      else           w_pos_wdata = {24'h000000, r_wdata[7:0]} << {r_off, 3'b000};
    end
  end

  always_comb begin
    w_merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_mem_be[i]) w_merged[8*i +: 8] = w_pos_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_mem_addr  <= 10'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we       <= we;
            r_size     <= size;
            r_sext     <= sign_ext;
            r_off      <= addr[1:0];
            r_wdata    <= wdata;
            r_mem_addr <= addr[11:2];
            r_mem_be   <= w_be;
            if (w_misaligned) begin
              r_state <= S_ERR;
            end else if (we && size[1]) begin
              r_mem_wdata <= wdata;
              r_state     <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_ERR:   r_state <= S_IDLE;
        S_READ:  r_state <= r_we ? S_MERGE : S_EXT;
        S_EXT: begin
          r_rdata <= w_load_val;
          r_state <= S_DONE;
        end
        S_MERGE: begin
          r_mem_wdata <= w_merged;
          r_state     <= S_WRITE;
        end
        S_WRITE: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign done      = (r_state == S_DONE) || (r_state == S_ERR);
  assign err       = (r_state == S_ERR);
  assign busy      = (r_state != S_IDLE);
  // A reset landing in the WRITE cycle must kill the strobe in that same cycle.
  assign mem_write = (r_state == S_WRITE) && !rst;

endmodule

// File: tb/tb_mem_ls_unit.sv
// Self-checking bench for mem_ls_unit: byte-level transaction model, per-cycle compare, directed vectors.
module tb_mem_ls_unit;

  logic        clk = 1'b0;
  logic        rst, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_wdata, mem_rdata;
  logic        done, err, busy, mem_write;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_ls_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Data memory: full-word writes, registered read; pl_* is a bench-side preload port.
  logic [31:0] ram [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = 10'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (pl_we)          ram[pl_addr]  <= pl_data;
    else if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: what the in-flight access must produce and when.
  logic [31:0] mdl_mem [0:1023];
  int          acc_cyc = -1000;
  int          m_lat   = 0;
  bit          m_err   = 1'b0;
  bit          m_store = 1'b0;
  logic [9:0]  m_waddr = 10'h0;
  logic [3:0]  m_be    = 4'h0;
  logic [31:0] m_new_word  = 32'h0;
  logic [31:0] m_new_rdata = 32'h0;
  logic [31:0] exp_rdata   = 32'h0;
  bit          cmp_en      = 1'b0;
  int          mw_pulses   = 0;
  logic [3:0]  last_be     = 4'h0;
  logic [31:0] last_wd     = 32'h0;

  // A reset drops the in-flight access and clears rdata.
  always @(posedge clk) begin
    if (rst) begin
      acc_cyc   = -1000;
      exp_rdata = 32'h0;
    end
  end

  always @(negedge clk) begin : cmp
    int  k;
    bit  e_busy, e_done, e_mw;
    if (cmp_en) begin
      k      = cyc - acc_cyc + 1;
      e_busy = (k >= 1) && (k <= m_lat);
      e_done = (k == m_lat);
      e_mw   = m_store && !m_err && (k == m_lat - 1) && !rst;
      if (e_done && !m_err && !m_store) exp_rdata = m_new_rdata;
      check("busy",      32'(busy),      32'(e_busy));
      check("done",      32'(done),      32'(e_done));
      check("err",       32'(err),       32'(e_done && m_err));
      check("mem_write", 32'(mem_write), 32'(e_mw));
      check("rdata",     rdata,          exp_rdata);
      if (e_busy) check("mem_addr", 32'(mem_addr), 32'(m_waddr));
      if (e_mw) begin
        check("mem_be",    32'(mem_be), 32'(m_be));
        check("mem_wdata", mem_wdata,   m_new_word);
      end
      if (mem_write) begin
        mw_pulses++;
        last_be = mem_be;
        last_wd = mem_wdata;
      end
      if (e_done && m_store && !m_err) mdl_mem[m_waddr] = m_new_word;
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    mdl_mem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Presents one request in an IDLE cycle and loads the model's expectations for it.
  task automatic issue(input bit w, input logic [1:0] sz, input bit se,
                       input logic [31:0] a, input logic [31:0] wd);
    int          nbytes, off;
    logic [31:0] old, nw, ld;
    logic [3:0]  be;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    nbytes = sz[1] ? 4 : (sz[0] ? 2 : 1);
    off    = int'(a[1:0]);
    old    = mdl_mem[a[11:2]];
    nw = old; ld = 32'h0; be = 4'h0;
    if ((off % nbytes) == 0) begin
      for (int i = 0; i < nbytes; i++) begin
        nw[8*(off+i) +: 8] = wd[8*i +: 8];
        ld[8*i +: 8]       = old[8*(off+i) +: 8];
        be[off+i]          = 1'b1;
      end
    end
    if (se && ld[8*nbytes-1])
      for (int i = nbytes; i < 4; i++) ld[8*i +: 8] = 8'hFF;
    @(posedge clk);
    #1;
    req         = 1'b0;
    acc_cyc     = cyc;
    m_err       = (off % nbytes) != 0;
    m_store     = w;
    m_waddr     = a[11:2];
    m_be        = be;
    m_new_word  = nw;
    m_new_rdata = ld;
    m_lat       = m_err ? 1 : (!w ? 3 : (nbytes == 4 ? 2 : 4));
  endtask

  // Runs to the negedge of the done cycle; the next issue lands in the first IDLE cycle.
  task automatic finish_txn();
    repeat (m_lat) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    preload(10'h004, 32'h884422F1);
    preload(10'h008, 32'h00000000);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_rdata",     rdata,           32'h0);
    check("rst_busy",      32'(busy),       32'h0);
    check("rst_done",      32'(done),       32'h0);
    check("rst_mem_addr",  32'(mem_addr),   32'h0);
    check("rst_mem_be",    32'(mem_be),     32'h0);
    check("rst_mem_wdata", mem_wdata,       32'h0);

    // Loads with extension from the preloaded word.
    mw_pulses = 0;
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0); finish_txn();
    check("ld_b_sext_done", 32'(done), 32'h1);
    check("ld_b_sext", rdata, 32'hFFFFFF88);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0); finish_txn();
    check("ld_h_zext", rdata, 32'h00008844);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0); finish_txn();
    check("ld_h_sext_pos", rdata, 32'h000022F1);
    check("ld_no_write", 32'(mw_pulses), 32'h0);

    // Byte store via read-modify-write, then read it back.
    mw_pulses = 0;
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB); finish_txn();
    check("st_b_pulses", 32'(mw_pulses), 32'h1);
    check("st_b_be",     32'(last_be),   32'h2);
    check("st_b_wdata",  last_wd,        32'h8844ABF1);
    check("st_b_ram",    ram[4],         32'h8844ABF1);
    check("st_b_rdata_kept", rdata,      32'h000022F1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); finish_txn();
    check("ld_w", rdata, 32'h8844ABF1);

    // Misaligned accesses error out without touching memory or rdata.
    mw_pulses = 0;
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hDEADBEEF); finish_txn();
    check("st_w_mis_err", 32'(err), 32'h1);
    issue(1'b0, 2'b01, 1'b1, 32'h11, 32'h0); finish_txn();
    check("ld_h_mis_err", 32'(err), 32'h1);
    check("mis_no_write", 32'(mw_pulses), 32'h0);
    check("mis_ram",      ram[4],         32'h8844ABF1);
    check("mis_rdata",    rdata,          32'h8844ABF1);

    // Reset during WRITE of a half store suppresses the write and the done pulse.
    preload(10'h004, 32'h884422F1);
    mw_pulses = 0;
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_busy_in_write", 32'(busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_busy_after", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    check("rstw_pulses", 32'(mw_pulses), 32'h0);
    check("rstw_ram",    ram[4],         32'h884422F1);
    check("rstw_rdata",  rdata,          32'h0);

    // Word store with req held high while busy: only one access, next accepted in first IDLE.
    mw_pulses = 0;
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D);
    repeat (m_lat) begin
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h20;
    end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0); finish_txn();
    check("hold_pulses", 32'(mw_pulses), 32'h1);
    check("hold_ram",    ram[8],         32'hCAFEF00D);
    check("hold_ld",     rdata,          32'hCAFEF00D);
    repeat (2) @(negedge clk);
    check("final_ram4", ram[4], mdl_mem[4]);
    check("final_ram8", ram[8], mdl_mem[8]);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
